funct_gen_sequencer: RTL and testbench
======================================

# funct_gen_sequencer

Run controller for the function generator core. It latches a host command (waveform, amplitude, burst length) and drives the generator's configuration and enable pins through a config/run sequence. It counts the samples the generator writes, pauses generation on FIFO back-pressure, and reports completion. It sits between the host/CSR side and the generator, whose `wr_en_o`/`data_o` feed the sample FIFO.

## Interface
Parameters:
- `INT_BITS`, 4, width of the amplitude code; matches the generator.
- `CNT_W`, 16, width of the burst-length field and the sample counter.
- `RESET_AMP_CODE`, 4'h1, amplitude code driven out of reset.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `start_i`, in, 1, one-cycle start request; accepted only in IDLE.
- `abort_i`, in, 1, stops any run; honoured in every state.
- `cfg_sel_i`, in, 2, waveform select (0 sin, 1 cos, 2 triangular, 3 square).
- `cfg_amp_i`, in, INT_BITS, signed amplitude code.
- `cfg_len_i`, in, CNT_W, samples per burst; 0 means continuous until abort.
- `fifo_afull_i`, in, 1, FIFO almost-full flag. The FIFO threshold leaves at least 2 free slots.
- `gen_wr_i`, in, 1, the generator's `wr_en_o`; one sample written per high cycle.
- `gen_en_low_o`, out, 1, active-low run enable to the generator.
- `gen_enh_conf_o`, out, 1, one-cycle configuration strobe to the generator.
- `gen_sel_o`, out, 2, latched waveform select.
- `gen_amp_o`, out, INT_BITS, latched amplitude code.
- `busy_o`, out, 1, high in every state except IDLE.
- `done_o`, out, 1, one-cycle pulse when a finite burst completes.
- `sample_cnt_o`, out, CNT_W, samples written in the current or last burst.

## Operation
- FSM states: IDLE, CONFIG, ARM, RUN, PAUSE, DONE.
- IDLE, start_i=1 and abort_i=0: go to CONFIG.
  - Latch `cfg_sel_i` into `gen_sel_o`, `cfg_amp_i` into `gen_amp_o`, and `cfg_len_i` into the internal length register.
  - Clear `sample_cnt_o`.
- CONFIG (1 cycle): `gen_enh_conf_o`=1, `gen_en_low_o`=1. Always goes to ARM.
- ARM (1 cycle): settle cycle for the generator's address clear. Always goes to RUN.
- RUN: `gen_en_low_o`=0.
  - Go to DONE when the counter reaches the length (length ≠ 0).
  - Otherwise go to PAUSE when `fifo_afull_i`=1.
- PAUSE: `gen_en_low_o`=1. Go back to RUN when `fifo_afull_i`=0.
- DONE (1 cycle): `done_o`=1, `gen_en_low_o`=1. Always goes to IDLE.
- Counter:
  - Increments on every `gen_wr_i`=1 cycle while in RUN or PAUSE. In-flight writes after a pause or stop are still counted.
  - Saturates at all-ones.
  - Holds its value in IDLE.
- Completion compare uses the post-increment value: count + `gen_wr_i` ≥ length. Overshoot from generator latency is allowed and stays visible on `sample_cnt_o`.
- Priorities within one cycle:
  - abort beats everything;
  - completion beats almost-full;
  - start while busy is ignored.
- Abort: next state is IDLE with `gen_en_low_o`=1 and no `done_o`. Latched sel/amp and the counter are kept.
- `gen_amp_o` is passed through unfiltered. The generator itself rejects the codes 0 and the most-negative value.

## Timing
- Reset values: FSM=IDLE, `gen_en_low_o`=1, `gen_enh_conf_o`=0, `gen_sel_o`=0, `gen_amp_o`=RESET_AMP_CODE, `busy_o`=0, `done_o`=0, `sample_cnt_o`=0.
- Reset asserted mid-run forces these values immediately (asynchronously).
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- From `start_i` sampled high:
  - `gen_enh_conf_o` high in cycle +1;
  - `gen_en_low_o` falls in cycle +3.
- `fifo_afull_i` high in RUN: `gen_en_low_o` rises on the next edge.
- Completion: `done_o` is high for the cycle after the final counted write. `busy_o` falls one cycle later.
- Back-to-back bursts: a new `start_i` is accepted on the first IDLE cycle after DONE.

## Structure
- Package `funct_gen_pkg` holds:
  - `typedef enum logic [2:0]` for `seq_state_t` (IDLE..DONE);
  - waveform select constants `SEL_SIN`, `SEL_COS`, `SEL_TRI`, `SEL_SQU`.
- Sub-module `funct_gen_sample_cnt`: saturating CNT_W counter with clear, enable, increment, and a `reached_o` compare against the length. The FSM stays in the top module.

## Test plan
- Reset, then start with len=4, sel=2, amp=3, `gen_wr_i` tied to ~`gen_en_low_o` → conf pulse at +1, run at +3, `done_o` after the 4th write, `sample_cnt_o`=4.
- len=10, `fifo_afull_i` high for cycles 5–8 of RUN → `gen_en_low_o` high during the pause; burst still ends with `sample_cnt_o`≥10 and a single `done_o`.
- len=0, run 300 cycles, then `abort_i` → never `done_o`; IDLE next cycle; `sample_cnt_o`=writes seen.
- `start_i` pulsed during RUN with sel=1 → ignored; `gen_sel_o` keeps its original value.
- Same-cycle final write and `fifo_afull_i`=1 → DONE, not PAUSE. Same-cycle start and abort in IDLE → stays IDLE.
- Reset asserted mid-RUN → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/funct_gen_pkg.sv
// Shared types and constants for the function generator run controller.
package funct_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    PAUSE  = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  localparam logic [1:0] SEL_SIN = 2'd0;
  localparam logic [1:0] SEL_COS = 2'd1;
  localparam logic [1:0] SEL_TRI = 2'd2;
  localparam logic [1:0] SEL_SQU = 2'd3;

endpackage

// File: rtl/funct_gen_sample_cnt.sv
// Saturating sample counter with a look-ahead compare against the burst length,
// so completion is flagged in the same cycle as the final write.
module funct_gen_sample_cnt
  import funct_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             reached_o
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_post;

  // One extra bit so the post-increment compare cannot wrap at all-ones.
  assign w_cnt_post = {1'b0, r_cnt} + {{CNT_W{1'b0}}, inc_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o     = r_cnt;
  assign reached_o = (len_i != '0) && (w_cnt_post >= {1'b0, len_i});

endmodule

// File: rtl/funct_gen_sequencer.sv
// Run controller for the function generator: latches a host command, walks
// config/arm/run, pauses on FIFO back-pressure and reports burst completion.
module funct_gen_sequencer
  import funct_gen_pkg::*;
#(
  parameter int                  INT_BITS       = 4,
  parameter int                  CNT_W          = 16,
  parameter logic [INT_BITS-1:0] RESET_AMP_CODE = 4'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          cfg_sel_i,
  input  logic [INT_BITS-1:0] cfg_amp_i,
  input  logic [CNT_W-1:0]    cfg_len_i,
  input  logic                fifo_afull_i,
  input  logic                gen_wr_i,
  output logic                gen_en_low_o,
  output logic                gen_enh_conf_o,
  output logic [1:0]          gen_sel_o,
  output logic [INT_BITS-1:0] gen_amp_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    sample_cnt_o
);

  seq_state_t          r_state;
  seq_state_t          w_state_next;
  logic [1:0]          r_sel;
  logic [INT_BITS-1:0] r_amp;
  logic [CNT_W-1:0]    r_len;
  logic                r_en_low;
  logic                r_conf;
  logic                r_done;
  logic                r_busy;
  logic                w_start_ok;
  logic                w_cnt_en;
  logic                w_reached;
  logic [CNT_W-1:0]    w_cnt;

  assign w_start_ok = (r_state == IDLE) && start_i && !abort_i;
  assign w_cnt_en   = (r_state == RUN) || (r_state == PAUSE);

  funct_gen_sample_cnt #(
    .CNT_W(CNT_W)
  ) u_sample_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_start_ok),
    .en_i     (w_cnt_en),
    .inc_i    (gen_wr_i),
    .len_i    (r_len),
    .cnt_o    (w_cnt),
    .reached_o(w_reached)
  );

  // Abort wins over everything; completion wins over back-pressure in RUN.
  always_comb begin
    w_state_next = r_state;
    if (abort_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start_i) w_state_next = CONFIG;
        CONFIG:  w_state_next = ARM;
        ARM:     w_state_next = RUN;
        RUN: begin
          if (w_reached)         w_state_next = DONE;
          else if (fifo_afull_i) w_state_next = PAUSE;
        end
        PAUSE:   if (!fifo_afull_i) w_state_next = RUN;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_en_low <= 1'b1;
      r_conf   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_sel    <= SEL_SIN;
      r_amp    <= RESET_AMP_CODE;
      r_len    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_en_low <= (w_state_next != RUN);
      r_conf   <= (w_state_next == CONFIG);
      r_done   <= (w_state_next == DONE);
      r_busy   <= (w_state_next != IDLE);
      if (w_start_ok) begin
        r_sel <= cfg_sel_i;
        r_amp <= cfg_amp_i;
        r_len <= cfg_len_i;
      end
    end
  end

  assign gen_en_low_o   = r_en_low;
  assign gen_enh_conf_o = r_conf;
  assign gen_sel_o      = r_sel;
  assign gen_amp_o      = r_amp;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign sample_cnt_o   = w_cnt;

endmodule

// File: tb/tb_funct_gen_sequencer.sv
// Self-checking bench for funct_gen_sequencer: randomized bursts against a
// cycle-timeline reference model of the run sequence.
module tb_funct_gen_sequencer;

  localparam int P_IDLE  = 0;
  localparam int P_CONF  = 1;
  localparam int P_ARM   = 2;
  localparam int P_RUN   = 3;
  localparam int P_PAUSE = 4;
  localparam int P_DONE  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  cfg_sel_i = 2'd0;
  logic [3:0]  cfg_amp_i = 4'd0;
  logic [15:0] cfg_len_i = 16'd0;
  logic        fifo_afull_i = 1'b0;
  logic        tie_wr = 1'b1;
  logic        wr_rand = 1'b0;
  logic        gen_wr_i;
  logic        gen_en_low_o;
  logic        gen_enh_conf_o;
  logic [1:0]  gen_sel_o;
  logic [3:0]  gen_amp_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] sample_cnt_o;

  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_sel = 2'd0;
  logic [3:0] exp_amp = 4'h1;
  int         exp_cnt = 0;
  int         last_done = 0;

  assign gen_wr_i = tie_wr ? ~gen_en_low_o : wr_rand;

  always #5 clk = ~clk;

  funct_gen_sequencer #(
    .INT_BITS(4),
    .CNT_W(16),
    .RESET_AMP_CODE(4'h1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .cfg_sel_i     (cfg_sel_i),
    .cfg_amp_i     (cfg_amp_i),
    .cfg_len_i     (cfg_len_i),
    .fifo_afull_i  (fifo_afull_i),
    .gen_wr_i      (gen_wr_i),
    .gen_en_low_o  (gen_en_low_o),
    .gen_enh_conf_o(gen_enh_conf_o),
    .gen_sel_o     (gen_sel_o),
    .gen_amp_o     (gen_amp_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .sample_cnt_o  (sample_cnt_o)
  );

  // Drives one burst from an IDLE cycle and checks every cycle. Timeline:
  // config, arm, then run; each later run/pause cycle follows the previous
  // cycle's almost-full, a run cycle whose write reaches len ends the burst.
  task automatic run_burst(input int len, input logic [1:0] sel, input logic [3:0] amp,
                           input int afull_pct, input int win_lo, input int win_hi,
                           input int abort_at, input int stray_at, input bit rnd_wr,
                           input int max_cyc);
    int ph;
    int w;
    bit afull;
    bit wr;
    bit finished;
    ph = P_CONF;
    w = 0;
    finished = 0;
    last_done = 0;
    abort_i = 1'b0;
    start_i = 1'b1;
    cfg_sel_i = sel;
    cfg_amp_i = amp;
    cfg_len_i = 16'(len);
    @(posedge clk); #1;
    exp_sel = sel;
    exp_amp = amp;
    for (int n = 0; n < max_cyc; n++) begin
      start_i = 1'b0;
      checks += 7;
      if (gen_en_low_o !== (ph != P_RUN)) begin
        errors++; $display("FAIL en_low n=%0d got=%b exp=%b", n, gen_en_low_o, (ph != P_RUN));
      end
      if (gen_enh_conf_o !== (ph == P_CONF)) begin
        errors++; $display("FAIL conf n=%0d got=%b exp=%b", n, gen_enh_conf_o, (ph == P_CONF));
      end
      if (done_o !== (ph == P_DONE)) begin
        errors++; $display("FAIL done n=%0d got=%b exp=%b", n, done_o, (ph == P_DONE));
      end
      if (busy_o !== (ph != P_IDLE)) begin
        errors++; $display("FAIL busy n=%0d got=%b exp=%b", n, busy_o, (ph != P_IDLE));
      end
      if (sample_cnt_o !== 16'(w)) begin
        errors++; $display("FAIL cnt n=%0d got=%0d exp=%0d", n, sample_cnt_o, w);
      end
      if (gen_sel_o !== exp_sel) begin
        errors++; $display("FAIL sel n=%0d got=%0d exp=%0d", n, gen_sel_o, exp_sel);
      end
      if (gen_amp_o !== exp_amp) begin
        errors++; $display("FAIL amp n=%0d got=%0d exp=%0d", n, gen_amp_o, exp_amp);
      end
      if (done_o === 1'b1) last_done++;
      if (ph == P_IDLE) begin
        finished = 1;
        break;
      end
      // Stray starts with fresh config while busy must have no effect.
      start_i   = (n == stray_at) || ($urandom_range(0, 7) == 0);
      cfg_sel_i = (n == stray_at) ? 2'd1 : 2'($urandom);
      cfg_amp_i = 4'($urandom);
      cfg_len_i = 16'($urandom_range(1, 5));
      afull = (n >= win_lo && n <= win_hi) || ($urandom_range(0, 99) < afull_pct);
      fifo_afull_i = afull;
      abort_i = (n == abort_at);
      tie_wr = !rnd_wr;
      wr_rand = 1'($urandom_range(0, 1));
      wr = rnd_wr ? wr_rand : (ph == P_RUN);
      if ((ph == P_RUN || ph == P_PAUSE) && wr && w < 65535) w++;
      if (n == abort_at) ph = P_IDLE;
      else if (ph == P_CONF) ph = P_ARM;
      else if (ph == P_ARM) ph = P_RUN;
      else if (ph == P_RUN && len != 0 && w >= len) ph = P_DONE;
      else if (ph == P_RUN || ph == P_PAUSE) ph = afull ? P_PAUSE : P_RUN;
      else if (ph == P_DONE) ph = P_IDLE;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    fifo_afull_i = 1'b0;
    tie_wr = 1'b1;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL burst_timeout got=busy exp=idle within %0d cycles", max_cyc);
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
    end
    exp_cnt = w;
    $display("burst len=%0d sel=%0d amp=%0d cnt=%0d done_pulses=%0d", len, sel, amp, w, last_done);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (gen_en_low_o !== 1'b1 || gen_enh_conf_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b%b%b%b exp=1000", gen_en_low_o, gen_enh_conf_o, busy_o, done_o);
    end
    if (gen_sel_o !== 2'd0 || gen_amp_o !== 4'h1 || sample_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_data got=%0d/%0d/%0d exp=0/1/0", gen_sel_o, gen_amp_o, sample_cnt_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || gen_en_low_o !== 1'b1) begin
      errors++; $display("FAIL reset_release got=%b%b exp=01", busy_o, gen_en_low_o);
    end
  endtask

  task automatic test_basic();
    run_burst(4, 2'd2, 4'd3, 0, -1, -1, -1, -1, 0, 40);
    checks += 2;
    if (last_done != 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", last_done); end
    if (sample_cnt_o !== 16'd4) begin errors++; $display("FAIL basic_cnt got=%0d exp=4", sample_cnt_o); end
  endtask

  task automatic test_pause();
    run_burst(10, 2'd0, 4'd5, 0, 6, 9, -1, -1, 0, 60);
    checks += 2;
    if (last_done != 1) begin errors++; $display("FAIL pause_done got=%0d exp=1", last_done); end
    if (sample_cnt_o < 16'd10) begin errors++; $display("FAIL pause_cnt got=%0d exp>=10", sample_cnt_o); end
  endtask

  task automatic test_continuous_abort();
    run_burst(0, 2'd3, 4'd7, 10, -1, -1, 300, -1, 0, 320);
    checks += 3;
    if (last_done != 0) begin errors++; $display("FAIL cont_done got=%0d exp=0", last_done); end
    if (sample_cnt_o !== 16'(exp_cnt)) begin errors++; $display("FAIL cont_cnt got=%0d exp=%0d", sample_cnt_o, exp_cnt); end
    if (gen_sel_o !== 2'd3) begin errors++; $display("FAIL cont_sel_kept got=%0d exp=3", gen_sel_o); end
  endtask

  task automatic test_start_ignored();
    run_burst(12, 2'd2, 4'd6, 0, -1, -1, -1, 5, 0, 60);
    checks += 2;
    if (gen_sel_o !== 2'd2) begin errors++; $display("FAIL stray_sel got=%0d exp=2", gen_sel_o); end
    if (last_done != 1) begin errors++; $display("FAIL stray_done got=%0d exp=1", last_done); end
  endtask

  task automatic test_done_vs_afull();
    // Fourth write lands in run cycle n=5 together with almost-full.
    run_burst(4, 2'd1, 4'd2, 0, 5, 5, -1, -1, 0, 40);
    checks += 2;
    if (last_done != 1) begin errors++; $display("FAIL final_afull_done got=%0d exp=1", last_done); end
    if (sample_cnt_o !== 16'd4) begin errors++; $display("FAIL final_afull_cnt got=%0d exp=4", sample_cnt_o); end
  endtask

  task automatic test_start_abort_idle();
    start_i = 1'b1;
    abort_i = 1'b1;
    cfg_sel_i = ~exp_sel;
    cfg_amp_i = ~exp_amp;
    cfg_len_i = 16'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    checks += 3;
    if (busy_o !== 1'b0 || gen_enh_conf_o !== 1'b0) begin
      errors++; $display("FAIL start_abort_state got=busy%b conf%b exp=busy0 conf0", busy_o, gen_enh_conf_o);
    end
    if (gen_sel_o !== exp_sel || gen_amp_o !== exp_amp) begin
      errors++; $display("FAIL start_abort_latch got=%0d/%0d exp=%0d/%0d", gen_sel_o, gen_amp_o, exp_sel, exp_amp);
    end
    if (sample_cnt_o !== 16'(exp_cnt)) begin
      errors++; $display("FAIL start_abort_cnt got=%0d exp=%0d", sample_cnt_o, exp_cnt);
    end
    $display("start+abort in idle: busy=%b sel=%0d", busy_o, gen_sel_o);
  endtask

  task automatic test_back_to_back();
    run_burst(3, 2'd0, 4'd4, 0, -1, -1, -1, -1, 0, 30);
    run_burst(2, 2'd3, 4'd9, 0, -1, -1, -1, -1, 0, 30);
    checks += 2;
    if (last_done != 1) begin errors++; $display("FAIL b2b_done got=%0d exp=1", last_done); end
    if (sample_cnt_o !== 16'd2) begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", sample_cnt_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++) begin
      int len;
      int ab;
      len = $urandom_range(0, 24);
      if (len == 0) ab = $urandom_range(20, 60);
      else if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 30);
      else ab = -1;
      run_burst(len, 2'($urandom), 4'($urandom), 25, -1, -1, ab, -1, 1, 500);
    end
  endtask

  task automatic test_reset_midrun();
    start_i = 1'b1;
    cfg_sel_i = 2'd3;
    cfg_amp_i = 4'd5;
    cfg_len_i = 16'd50;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks += 2;
    if (gen_en_low_o !== 1'b1 || gen_enh_conf_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_ctrl got=%b%b%b%b exp=1000", gen_en_low_o, gen_enh_conf_o, busy_o, done_o);
    end
    if (gen_sel_o !== 2'd0 || gen_amp_o !== 4'h1 || sample_cnt_o !== 16'd0) begin
      errors++; $display("FAIL midrun_reset_data got=%0d/%0d/%0d exp=0/1/0", gen_sel_o, gen_amp_o, sample_cnt_o);
    end
    $display("async reset mid-run: busy=%b cnt=%0d", busy_o, sample_cnt_o);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sel = 2'd0;
    exp_amp = 4'h1;
    exp_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_continuous_abort();
    test_start_ignored();
    test_done_vs_afull();
    test_start_abort_idle();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    test_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
